pwl_act_stream: RTL and testbench

PWL_ACT_STREAM -- requirements
Module: pwl_act_stream

---
 rtl/pwl_act_stream.sv | 172 +++++++++++++++++
 tb/tb_pwl_act_stream.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_act_stream.sv
// rtl/pwl_act_stream.sv - streaming piecewise-linear activation, 3-stage pipeline
//
// Purpose: y = sat(floor(x * slope[seg] / 2^FRAC_W) + icpt[seg]), where seg is the
// lowest entry with x < bound[seg] (last entry if none). The table resets to a tanh
// approximation and is writable only while the pipeline is empty.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake, x_in sample (signed, FRAC_W fraction bits)
//   out_valid/out_ready output handshake, y_out result, y_sat clipped flag
//   cfg_we/cfg_ready    table write handshake (cfg_ready = pipeline empty)
//   cfg_sel             0 bound, 1 slope, 2 intercept, 3 ignored
//   cfg_addr, cfg_wdata segment index and value
//   busy                some pipeline stage holds a sample
module pwl_act_stream #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int NSEG   = 8,
  localparam int AW    = $clog2(NSEG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_sat,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_sel,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [DATA_W-1:0]        cfg_wdata,
  output logic                     cfg_ready,
  output logic                     busy
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 1;
  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Default tanh table; entries past 4 repeat entry 4.
  function automatic logic signed [DATA_W-1:0] def_bound(input int i);
    case (i)
      0:       return DATA_W'(-512);
      1:       return DATA_W'(-128);
      2:       return DATA_W'(128);
      3:       return DATA_W'(512);
      default: return DATA_W'(32767);
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] def_slope(input int i);
    case (i)
      0:       return DATA_W'(0);
      1:       return DATA_W'(86);
      2:       return DATA_W'(236);
      3:       return DATA_W'(86);
      default: return DATA_W'(0);
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] def_icpt(input int i);
    case (i)
      0:       return DATA_W'(-256);
      1:       return DATA_W'(-75);
      2:       return DATA_W'(0);
      3:       return DATA_W'(75);
      default: return DATA_W'(256);
    endcase
  endfunction

  logic signed [DATA_W-1:0] bound_q [NSEG];
  logic signed [DATA_W-1:0] slope_q [NSEG];
  logic signed [DATA_W-1:0] icpt_q  [NSEG];

  logic                     v1, v2;
  logic signed [DATA_W-1:0] x1;
  logic [AW-1:0]            seg1;
  logic signed [PW-1:0]     sh2;
  logic signed [DATA_W-1:0] icpt2;

  logic                     stall, accept, cfg_wr;
  logic [AW-1:0]            seg_in;
  logic signed [PW-1:0]     prod;
  logic signed [SW-1:0]     sum;
  logic signed [DATA_W-1:0] y_next;
  logic                     sat_next;

  assign busy      = v1 | v2 | out_valid;
  assign cfg_ready = !busy;
  assign cfg_wr    = cfg_we && cfg_ready;
  assign stall     = out_valid && !out_ready;
  // A write that is taken this cycle blocks the sample so it sees the new table.
  assign in_ready  = !stall && !cfg_wr;
  assign accept    = in_valid && in_ready;

  // Lowest matching entry wins: scan from the top so lower indices overwrite.
  always_comb begin
    seg_in = AW'(NSEG - 1);
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (x_in < bound_q[i]) seg_in = AW'(i);
    end
  end

  // Table is stable while samples are in flight, so S1 can index it directly.
  assign prod = PW'(x1) * PW'(slope_q[seg1]);

  always_comb begin
    sum      = SW'(sh2) + SW'(icpt2);
    y_next   = sum[DATA_W-1:0];
    sat_next = 1'b0;
    if (sum > SW'(D_MAX)) begin
      y_next   = D_MAX;
      sat_next = 1'b1;
    end else if (sum < SW'(D_MIN)) begin
      y_next   = D_MIN;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        bound_q[i] <= def_bound(i);
        slope_q[i] <= def_slope(i);
        icpt_q[i]  <= def_icpt(i);
      end
    end else if (cfg_wr) begin
      case (cfg_sel)
        2'd0:    bound_q[cfg_addr] <= cfg_wdata;
        2'd1:    slope_q[cfg_addr] <= cfg_wdata;
        2'd2:    icpt_q[cfg_addr]  <= cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      seg1      <= '0;
      sh2       <= '0;
      icpt2     <= '0;
      y_out     <= '0;
      y_sat     <= 1'b0;
    end else if (!stall) begin
      v1        <= accept;
      v2        <= v1;
      out_valid <= v2;
      if (accept) begin
        x1   <= x_in;
        seg1 <= seg_in;
      end
      if (v1) begin
        sh2   <= prod >>> FRAC_W;
        icpt2 <= icpt_q[seg1];
      end
      // Result registers only move when a real sample arrives, so they hold
      // across bubbles.
      if (v2) begin
        y_out <= y_next;
        y_sat <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_pwl_act_stream.sv
// tb/tb_pwl_act_stream.sv - self-checking bench for pwl_act_stream
module tb_pwl_act_stream;

  localparam int DW = 16;
  localparam int NS = 8;
  localparam int AW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] y_out;
  logic                 y_sat;
  logic                 cfg_we;
  logic [1:0]           cfg_sel;
  logic [AW-1:0]        cfg_addr;
  logic [DW-1:0]        cfg_wdata;
  logic                 cfg_ready;
  logic                 busy;

  always #5 clk = ~clk;

  pwl_act_stream #(.DATA_W(DW), .FRAC_W(8), .NSEG(NS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .y_sat(y_sat),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference table and arithmetic, straight from the activation definition.
  int m_bound [NS];
  int m_slope [NS];
  int m_icpt  [NS];

  function automatic void model_reset();
    int b[5] = '{-512, -128, 128, 512, 32767};
    int s[5] = '{0, 86, 236, 86, 0};
    int c[5] = '{-256, -75, 0, 75, 256};
    for (int i = 0; i < NS; i++) begin
      m_bound[i] = b[(i < 4) ? i : 4];
      m_slope[i] = s[(i < 4) ? i : 4];
      m_icpt[i]  = c[(i < 4) ? i : 4];
    end
  endfunction

  function automatic int model_y(input int x, output bit sat);
    int     seg = NS - 1;
    longint p, q, y;
    for (int i = 0; i < NS; i++) begin
      if (x < m_bound[i]) begin
        seg = i;
        break;
      end
    end
    p = longint'(x) * longint'(m_slope[seg]);
    q = p / 256;
    if ((p % 256 != 0) && (p < 0)) q = q - 1;
    y = q + longint'(m_icpt[seg]);
    sat = 1'b0;
    if (y > 32767) begin
      y = 32767;
      sat = 1'b1;
    end else if (y < -32768) begin
      y = -32768;
      sat = 1'b1;
    end
    return int'(y);
  endfunction

  typedef struct {
    int y;
    bit s;
    bit has_lit;
    int lit;
    bit lit_s;
    int cyc;
    int stl;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   stalls = 0;
  int   popped = 0;
  bit   prev_stall = 1'b0;
  logic signed [DW-1:0] prev_y = '0;
  logic prev_s = 1'b0;

  // Literal expectation attached to the next accepted sample.
  bit cur_has = 1'b0;
  int cur_lit = 0;
  bit cur_s = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      model_reset();
      prev_stall = 1'b0;
      prev_y = '0;
      prev_s = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y_out", y_out, 0);
      chk("rst_y_sat", y_sat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cfg_ready", cfg_ready, 1);
    end else begin
      bit mbusy;
      bit s;
      int yv;
      cyc++;
      mbusy = (q.size() != 0);
      chk("busy", busy, mbusy);
      chk("cfg_ready", cfg_ready, !mbusy);
      chk("in_ready", in_ready, !(out_valid && !out_ready) && !(cfg_we && !mbusy));
      if (prev_stall || !out_valid) begin
        chk("hold_y", y_out, prev_y);
        chk("hold_sat", y_sat, prev_s);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          popped++;
          chk("y_out", y_out, e.y);
          chk("y_sat", y_sat, e.s);
          if (e.has_lit) begin
            chk("y_lit", y_out, e.lit);
            chk("sat_lit", y_sat, e.lit_s);
          end
          if (e.stl == stalls) chk("latency", cyc - e.cyc, 3);
        end
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) stalls++;
      prev_y = y_out;
      prev_s = y_sat;
      if (cfg_we && cfg_ready) begin
        case (cfg_sel)
          2'd0: m_bound[cfg_addr] = int'($signed(cfg_wdata));
          2'd1: m_slope[cfg_addr] = int'($signed(cfg_wdata));
          2'd2: m_icpt[cfg_addr]  = int'($signed(cfg_wdata));
          default: ;
        endcase
      end
      if (in_valid && in_ready) begin
        yv = model_y(int'(x_in), s);
        q.push_back('{y: yv, s: s, has_lit: cur_has, lit: cur_lit, lit_s: cur_s,
                      cyc: cyc, stl: stalls});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one sample until accepted; lit_on attaches a hand-computed result.
  task automatic send(input int x, input bit lit_on, input int lit, input bit lit_s);
    bit ok = 1'b0;
    in_valid = 1'b1;
    x_in = DW'(x);
    cur_has = lit_on;
    cur_lit = lit;
    cur_s = lit_s;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    cur_has = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic cfg_write(input int sel, input int addr, input int data, output bit ok);
    cfg_we = 1'b1;
    cfg_sel = 2'(sel);
    cfg_addr = AW'(addr);
    cfg_wdata = DW'(data);
    @(negedge clk);
    ok = cfg_ready;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      if (q.size() == 0 && !busy) done = 1'b1;
      else tick();
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  int def_x[5]  = '{256, 64, -64, -1024, 600};
  int def_y[5]  = '{161, 59, -59, -256, 256};
  int bnd_x[6]  = '{-512, -129, 127, 128, 511, 512};
  int bnd_y[6]  = '{-247, -119, 117, 118, 246, 256};
  int bp_x[6]   = '{256, 64, -64, -1024, 600, 511};

  initial begin
    bit ok;
    bit s;
    int n0;
    rst = 1'b1;
    in_valid = 1'b0;
    x_in = '0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_sel = '0;
    cfg_addr = '0;
    cfg_wdata = '0;

    // Pin the model itself against hand-computed values.
    model_reset();
    for (int i = 0; i < 5; i++) chk("model_def", model_y(def_x[i], s), def_y[i]);
    for (int i = 0; i < 6; i++) chk("model_bnd", model_y(bnd_x[i], s), bnd_y[i]);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Default table, back to back.
    for (int i = 0; i < 5; i++) send(def_x[i], 1'b1, def_y[i], 1'b0);
    drain();

    // Segment boundaries.
    for (int i = 0; i < 6; i++) send(bnd_x[i], 1'b1, bnd_y[i], 1'b0);
    drain();

    // Reserved field is acknowledged and ignored.
    cfg_write(3, 3, 0, ok);
    chk("cfg_sel3_ack", ok, 1);
    send(256, 1'b1, 161, 1'b0);
    drain();

    // Write attempt while busy is refused.
    send(256, 1'b1, 161, 1'b0);
    cfg_write(1, 3, 0, ok);
    chk("cfg_busy_refused", ok, 0);
    drain();
    send(256, 1'b1, 161, 1'b0);
    drain();

    // Simultaneous write and sample while idle: write wins.
    cfg_we = 1'b1;
    cfg_sel = 2'd2;
    cfg_addr = 3'd3;
    cfg_wdata = DW'(100);
    in_valid = 1'b1;
    x_in = DW'(64);
    @(negedge clk);
    chk("simul_in_ready", in_ready, 0);
    chk("simul_cfg_ready", cfg_ready, 1);
    tick();
    cfg_we = 1'b0;
    send(64, 1'b1, 59, 1'b0);
    send(256, 1'b1, 186, 1'b0);
    drain();

    // Saturation: top segments get a huge slope; 32767 falls past bound[4].
    for (int a = 4; a < NS; a++) begin
      cfg_write(1, a, 32767, ok);
      chk("cfg_slope_ack", ok, 1);
      cfg_write(2, a, 0, ok);
      chk("cfg_icpt_ack", ok, 1);
    end
    send(32767, 1'b1, 32767, 1'b1);
    send(-32768, 1'b1, -256, 1'b0);
    drain();

    // Backpressure: out_ready low for cycles 3-8 of the stream.
    n0 = popped;
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_x[i], 1'b0, 0, 1'b0);
      end
      begin
        for (int c = 0; c < 20; c++) begin
          out_ready = !(c >= 3 && c <= 8);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", popped - n0, 6);

    // Reset mid-stream.
    send(64, 1'b0, 0, 1'b0);
    send(-64, 1'b0, 0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
      tick();
    end
    send(256, 1'b1, 161, 1'b0);
    send(600, 1'b1, 256, 1'b0);
    send(32767, 1'b1, 256, 1'b0);
    drain();
    chk("queue_empty_end", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
